// File: rtl/nonce_dispatcher_pkg.sv
// nonce_dispatcher_pkg: shared miner widths, dispatcher state encoding and golden-nonce helper
package nonce_dispatcher_pkg;
  localparam int NONCE_W = 32;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W = 96;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  // Nonce that was issued LATENCY cycles before the issue counter reached `issue`
  function automatic logic [NONCE_W-1:0] golden_of(input logic [NONCE_W-1:0] issue, input logic [NONCE_W-1:0] offset);
    return issue - offset;
  endfunction
endpackage

// File: rtl/nonce_dispatcher_if.sv
// nonce_dispatcher_if: work, nonce, hit and golden-result signals; slave = dispatcher, master = work source / cores / result sink
interface nonce_dispatcher_if;
  import nonce_dispatcher_pkg::*;
  logic rx_work_valid;
  logic tx_work_ready;
  logic [MIDSTATE_W-1:0] rx_midstate;
  logic [DATA_W-1:0] rx_data;
  logic [MIDSTATE_W-1:0] tx_midstate;
  logic [DATA_W-1:0] tx_data;
  logic [NONCE_W-1:0] tx_nonce;
  logic tx_hash_en;
  logic rx_hit;
  logic tx_golden_valid;
  logic [NONCE_W-1:0] tx_golden_nonce;
  logic rx_golden_ready;
  logic tx_exhausted;
  logic [7:0] tx_dropped;
  modport slave (
    input rx_work_valid, rx_midstate, rx_data, rx_hit, rx_golden_ready,
    output tx_work_ready, tx_midstate, tx_data, tx_nonce, tx_hash_en,
    output tx_golden_valid, tx_golden_nonce, tx_exhausted, tx_dropped
  );
  modport master (
    output rx_work_valid, rx_midstate, rx_data, rx_hit, rx_golden_ready,
    input tx_work_ready, tx_midstate, tx_data, tx_nonce, tx_hash_en,
    input tx_golden_valid, tx_golden_nonce, tx_exhausted, tx_dropped
  );
endinterface

// File: rtl/golden_fifo.sv
// golden_fifo: 2-entry result FIFO; ports clk/rst, i_push/i_din write, i_pop read, o_dout head, o_full/o_empty status
module golden_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_dout
);
  logic [W-1:0] r_mem [2];
  logic r_wp, r_rp;
  logic [1:0] r_cnt;
  // The caller never pushes into a full FIFO without popping in the same
  // cycle; in that case the write lands in the slot being vacated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end
  assign o_full = r_cnt == 2'd2;
  assign o_empty = r_cnt == 2'd0;
  assign o_dout = r_mem[r_rp];
endmodule

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: accepts work, sweeps the nonce space, maps core hits back to golden nonces; ports hash_clk, reset, bus (slave)
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int NONCE_STEP = 1,
  parameter int LATENCY = 64
) (
  input logic hash_clk,
  input logic reset,
  nonce_dispatcher_if.slave bus
);
  localparam logic [NONCE_W-1:0] STEP = NONCE_W'(NONCE_STEP);
  localparam logic [NONCE_W-1:0] LAST = NONCE_W'(0) - STEP;
  localparam logic [NONCE_W-1:0] OFFSET = NONCE_W'(LATENCY * NONCE_STEP);
  localparam logic [7:0] LAT8 = 8'(LATENCY);
  state_t r_state, w_state_nx;
  logic [NONCE_W-1:0] r_nonce;
  logic [MIDSTATE_W-1:0] r_mid;
  logic [DATA_W-1:0] r_data;
  logic [7:0] r_flush, r_drain, r_dropped;
  logic r_exh;
  logic w_xfer, w_hit_ok, w_pop, w_push, w_drop, w_full, w_empty;
  logic [NONCE_W-1:0] w_dout;
  assign bus.tx_work_ready = r_state != DRAIN;
  assign w_xfer = bus.rx_work_valid && bus.tx_work_ready;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = w_xfer ? RUN :
                 (r_state == RUN && r_nonce == LAST) ? DRAIN :
                 (r_state == DRAIN && r_drain == 8'd0) ? IDLE : r_state;
  end
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  // A non-zero flush count means the hit pipeline still carries nonces
  // from before the latest work was accepted (or none at all yet).
  assign w_hit_ok = bus.rx_hit && r_state != IDLE && r_flush == 8'd0;
  assign w_pop = bus.rx_golden_ready && !w_empty;
  assign w_push = w_hit_ok && (!w_full || w_pop);
  assign w_drop = w_hit_ok && w_full && !w_pop;
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      r_nonce <= '0;
      r_mid <= '0;
      r_data <= '0;
      r_flush <= '0;
      r_drain <= '0;
      r_dropped <= '0;
      r_exh <= 1'b0;
    end else begin
      r_exh <= r_state == DRAIN && w_state_nx == IDLE;
      // The drain counter reloads outside DRAIN so it is ready on entry.
      r_drain <= (r_state == DRAIN) ? r_drain - 8'd1 : LAT8 - 8'd1;
      if (w_xfer) begin
        r_mid <= bus.rx_midstate;
        r_data <= bus.rx_data;
        r_nonce <= '0;
        r_flush <= LAT8;
      end else begin
        if (r_state != IDLE) r_nonce <= r_nonce + STEP;
        if (r_flush != 8'd0) r_flush <= r_flush - 8'd1;
      end
      if (w_drop && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
    end
  end
  golden_fifo #(.W(NONCE_W)) u_fifo (
    .clk(hash_clk),
    .rst(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(golden_of(r_nonce, OFFSET)),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_dout(w_dout)
  );
  assign bus.tx_midstate = r_mid;
  assign bus.tx_data = r_data;
  assign bus.tx_nonce = r_nonce;
  assign bus.tx_hash_en = r_state == RUN;
  assign bus.tx_golden_valid = !w_empty;
  assign bus.tx_golden_nonce = w_dout;
  assign bus.tx_exhausted = r_exh;
  assign bus.tx_dropped = r_dropped;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb_nonce_dispatcher: randomized and directed checks of nonce_dispatcher against an issue-history model
module tb_nonce_dispatcher;
  localparam int LAT = 64;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  nonce_dispatcher_if bus_a ();
  nonce_dispatcher_if bus_b ();
  nonce_dispatcher #(.NONCE_STEP(1), .LATENCY(LAT)) u_a (.hash_clk(clk), .reset(rst_a), .bus(bus_a));
  nonce_dispatcher #(.NONCE_STEP(4), .LATENCY(LAT)) u_b (.hash_clk(clk), .reset(rst_b), .bus(bus_b));
  typedef struct {
    bit v;
    int id;
    logic [31:0] n;
  } issue_t;
  issue_t hist[$];
  int m_state;
  int m_id = 0;
  int m_drain;
  logic [31:0] m_nonce;
  logic [255:0] m_mid;
  logic [95:0] m_data;
  logic [31:0] m_q[$];
  logic [7:0] m_drop;
  logic m_exh;

  task automatic model_reset();
    m_state = 0;
    m_nonce = '0;
    m_mid = '0;
    m_data = '0;
    m_q.delete();
    hist.delete();
    m_drop = '0;
    m_exh = 1'b0;
  endtask

  // Drives one cycle on instance A, advances the reference model, then compares all outputs.
  task automatic cycle_a(input bit valid, input bit hit, input bit gready);
    logic [255:0] mid;
    logic [95:0] data;
    issue_t e, cur;
    bit ok, pop, xfer;
    mid = {8{$urandom()}};
    data = {3{$urandom()}};
    bus_a.rx_work_valid = valid;
    bus_a.rx_midstate = mid;
    bus_a.rx_data = data;
    bus_a.rx_hit = hit;
    bus_a.rx_golden_ready = gready;
    xfer = valid && m_state != 2;
    cur.v = m_state == 1;
    cur.id = m_id;
    cur.n = m_nonce;
    hist.push_back(cur);
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    ok = 1'b0;
    e = cur;
    if (hit && m_state != 0 && hist.size() == LAT + 1) begin
      e = hist[0];
      ok = e.v && e.id == m_id;
    end
    pop = gready && m_q.size() > 0;
    if (pop) void'(m_q.pop_front());
    if (ok) begin
      if (m_q.size() < 2) m_q.push_back(e.n);
      else if (m_drop != 8'hFF) m_drop++;
    end
    m_exh = 1'b0;
    if (xfer) begin
      m_id++;
      m_mid = mid;
      m_data = data;
      m_nonce = '0;
      m_state = 1;
    end else if (m_state == 1) begin
      if (m_nonce == 32'hFFFFFFFF) begin
        m_state = 2;
        m_drain = LAT;
      end
      m_nonce++;
    end else if (m_state == 2) begin
      m_drain--;
      if (m_drain == 0) begin
        m_state = 0;
        m_exh = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.tx_work_ready !== (m_state != 2)) begin errors++; $display("FAIL a_ready got %b want %b", bus_a.tx_work_ready, m_state != 2); end
    checks++;
    if (bus_a.tx_hash_en !== (m_state == 1)) begin errors++; $display("FAIL a_hash_en got %b want %b", bus_a.tx_hash_en, m_state == 1); end
    if (m_state == 1) begin
      checks++;
      if (bus_a.tx_nonce !== m_nonce) begin errors++; $display("FAIL a_nonce got %h want %h", bus_a.tx_nonce, m_nonce); end
    end
    checks++;
    if (bus_a.tx_midstate !== m_mid || bus_a.tx_data !== m_data) begin errors++; $display("FAIL a_work got %h/%h want %h/%h", bus_a.tx_midstate, bus_a.tx_data, m_mid, m_data); end
    checks++;
    if (bus_a.tx_golden_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL a_golden_valid got %b want %b", bus_a.tx_golden_valid, m_q.size() > 0); end
    if (m_q.size() > 0) begin
      checks++;
      if (bus_a.tx_golden_nonce !== m_q[0]) begin errors++; $display("FAIL a_golden_nonce got %h want %h", bus_a.tx_golden_nonce, m_q[0]); end
    end
    checks++;
    if (bus_a.tx_exhausted !== m_exh) begin errors++; $display("FAIL a_exhausted got %b want %b", bus_a.tx_exhausted, m_exh); end
    checks++;
    if (bus_a.tx_dropped !== m_drop) begin errors++; $display("FAIL a_dropped got %0d want %0d", bus_a.tx_dropped, m_drop); end
  endtask

  task automatic test_reset();
    bus_a.rx_work_valid = 1'b0;
    bus_a.rx_hit = 1'b0;
    bus_a.rx_golden_ready = 1'b0;
    bus_a.rx_midstate = '0;
    bus_a.rx_data = '0;
    @(negedge clk);
    checks++;
    if (bus_a.tx_work_ready !== 1'b1 || bus_a.tx_hash_en !== 1'b0 || bus_a.tx_nonce !== 32'd0) begin
      errors++; $display("FAIL reset_ctrl got rdy=%b en=%b n=%h want 1 0 0", bus_a.tx_work_ready, bus_a.tx_hash_en, bus_a.tx_nonce);
    end
    checks++;
    if (bus_a.tx_midstate !== '0 || bus_a.tx_data !== '0) begin errors++; $display("FAIL reset_work got %h/%h want 0", bus_a.tx_midstate, bus_a.tx_data); end
    checks++;
    if (bus_a.tx_golden_valid !== 1'b0 || bus_a.tx_exhausted !== 1'b0 || bus_a.tx_dropped !== 8'd0) begin
      errors++; $display("FAIL reset_result got v=%b x=%b d=%0d want 0 0 0", bus_a.tx_golden_valid, bus_a.tx_exhausted, bus_a.tx_dropped);
    end
    rst_a = 1'b0;
    model_reset();
  endtask

  task automatic test_issue();
    cycle_a(1, 0, 0);
    checks++;
    if (bus_a.tx_hash_en !== 1'b1 || bus_a.tx_nonce !== 32'd0) begin errors++; $display("FAIL issue_first got en=%b n=%h want 1 0", bus_a.tx_hash_en, bus_a.tx_nonce); end
    for (int i = 0; i < 3; i++) cycle_a(0, 0, 0);
    checks++;
    if (bus_a.tx_nonce !== 32'd3) begin errors++; $display("FAIL issue_third got %h want 3", bus_a.tx_nonce); end
  endtask

  task automatic test_golden();
    cycle_a(1, 0, 0);
    for (int k = 0; k < 63; k++) cycle_a(0, 0, 0);
    cycle_a(0, 1, 0);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b0) begin errors++; $display("FAIL early_hit got valid %b want 0", bus_a.tx_golden_valid); end
    cycle_a(0, 1, 1);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b1 || bus_a.tx_golden_nonce !== 32'd0) begin errors++; $display("FAIL first_hit got %b/%h want 1/0", bus_a.tx_golden_valid, bus_a.tx_golden_nonce); end
    for (int k = 65; k < 100; k++) cycle_a(0, 0, 1);
    cycle_a(0, 1, 0);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b1 || bus_a.tx_golden_nonce !== 32'd36) begin errors++; $display("FAIL hit_100 got %b/%h want 1/24", bus_a.tx_golden_valid, bus_a.tx_golden_nonce); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d0;
    d0 = m_drop;
    cycle_a(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle_a(0, 1, 0);
    cycle_a(0, 0, 0);
    checks++;
    if (bus_a.tx_golden_nonce !== 32'd38 || bus_a.tx_dropped !== d0 + 8'd1) begin errors++; $display("FAIL fifo_full got %h/%0d want 26/%0d", bus_a.tx_golden_nonce, bus_a.tx_dropped, d0 + 8'd1); end
    cycle_a(0, 0, 1);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b1 || bus_a.tx_golden_nonce !== 32'd39) begin errors++; $display("FAIL fifo_second got %b/%h want 1/27", bus_a.tx_golden_valid, bus_a.tx_golden_nonce); end
    cycle_a(0, 0, 1);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got %b want 0", bus_a.tx_golden_valid); end
  endtask

  task automatic test_restart();
    logic [7:0] d0;
    d0 = m_drop;
    cycle_a(1, 0, 1);
    for (int k = 0; k < 10; k++) cycle_a(0, 0, 1);
    cycle_a(0, 1, 1);
    cycle_a(0, 0, 1);
    checks++;
    if (bus_a.tx_golden_valid !== 1'b0 || bus_a.tx_dropped !== d0 || bus_a.tx_nonce !== 32'd12) begin
      errors++; $display("FAIL restart got v=%b d=%0d n=%h want 0 %0d c", bus_a.tx_golden_valid, bus_a.tx_dropped, bus_a.tx_nonce, d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++)
      cycle_a($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 400; i++) cycle_a(0, 1, 0);
    checks++;
    if (bus_a.tx_dropped !== 8'hFF) begin errors++; $display("FAIL saturate got %0d want 255", bus_a.tx_dropped); end
  endtask

  // Accepts work on instance B, jumps the counter near the top, returns once tx_hash_en drops (drain cycle 0).
  task automatic run_b_to_drain(output logic [31:0] last, output bit ok);
    logic [255:0] mid;
    mid = {8{$urandom()}};
    bus_b.rx_work_valid = 1'b1;
    bus_b.rx_midstate = mid;
    @(posedge clk);
    @(negedge clk);
    bus_b.rx_work_valid = 1'b0;
    checks++;
    if (bus_b.tx_hash_en !== 1'b1 || bus_b.tx_nonce !== 32'd0 || bus_b.tx_midstate !== mid) begin
      errors++; $display("FAIL b_accept got en=%b n=%h want 1 0", bus_b.tx_hash_en, bus_b.tx_nonce);
    end
    force u_b.r_nonce = 32'hFFFFFF00;
    #1 release u_b.r_nonce;
    last = '0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_b.tx_hash_en) last = bus_b.tx_nonce;
      else ok = 1'b1;
    end
  endtask

  task automatic test_exhaust();
    logic [31:0] last;
    bit ok, done;
    int d;
    bus_b.rx_hit = 1'b0;
    bus_b.rx_golden_ready = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    run_b_to_drain(last, ok);
    checks++;
    if (!ok || last !== 32'hFFFFFFFC) begin errors++; $display("FAIL b_last got %h done=%b want fffffffc 1", last, ok); end
    checks++;
    if (bus_b.tx_work_ready !== 1'b0) begin errors++; $display("FAIL b_drain_ready got %b want 0", bus_b.tx_work_ready); end
    d = 0;
    done = 1'b0;
    while (!done && d < 300) begin
      bus_b.rx_hit = d == 10;
      if (d == 11) begin
        checks++;
        if (bus_b.tx_golden_valid !== 1'b1 || bus_b.tx_golden_nonce !== 32'hFFFFFF28) begin
          errors++; $display("FAIL b_drain_hit got %b/%h want 1/ffffff28", bus_b.tx_golden_valid, bus_b.tx_golden_nonce);
        end
      end
      if (bus_b.tx_exhausted) done = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        d++;
      end
    end
    checks++;
    if (d != LAT) begin errors++; $display("FAIL b_drain_len got %0d want %0d", d, LAT); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_b.tx_exhausted !== 1'b0 || bus_b.tx_work_ready !== 1'b1 || bus_b.tx_hash_en !== 1'b0) begin
      errors++; $display("FAIL b_after got x=%b rdy=%b en=%b want 0 1 0", bus_b.tx_exhausted, bus_b.tx_work_ready, bus_b.tx_hash_en);
    end
  endtask

  task automatic test_reset_drain();
    logic [31:0] last;
    bit ok, seen;
    run_b_to_drain(last, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_redrain got timeout want drain"); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus_b.tx_golden_valid !== 1'b1) begin errors++; $display("FAIL b_pending got %b want 1", bus_b.tx_golden_valid); end
    #2 rst_b = 1'b1;
    #1;
    checks++;
    if (bus_b.tx_hash_en !== 1'b0 || bus_b.tx_nonce !== 32'd0 || bus_b.tx_midstate !== '0 || bus_b.tx_data !== '0) begin
      errors++; $display("FAIL b_async_work got en=%b n=%h want 0 0", bus_b.tx_hash_en, bus_b.tx_nonce);
    end
    checks++;
    if (bus_b.tx_golden_valid !== 1'b0 || bus_b.tx_exhausted !== 1'b0 || bus_b.tx_dropped !== 8'd0 || bus_b.tx_work_ready !== 1'b1) begin
      errors++; $display("FAIL b_async_res got v=%b x=%b d=%0d r=%b want 0 0 0 1", bus_b.tx_golden_valid, bus_b.tx_exhausted, bus_b.tx_dropped, bus_b.tx_work_ready);
    end
    @(negedge clk);
    rst_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_b.tx_exhausted || bus_b.tx_golden_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL b_no_exhaust got activity after reset want none"); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_b.rx_work_valid = 1'b0;
    bus_b.rx_midstate = '0;
    bus_b.rx_data = '0;
    bus_b.rx_hit = 1'b0;
    bus_b.rx_golden_ready = 1'b0;
    test_reset();
    test_issue();
    test_golden();
    test_fifo_full();
    test_restart();
    test_random();
    test_saturate();
    test_exhaust();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 SHALL have parameter NONCE_STEP, default 1: nonce increment per cycle, a power of two from 1 to 256.
REQ-002 SHALL have parameter LATENCY, default 64: cycles from nonce issue to the matching rx_hit, 1 to 255.
REQ-003 hash_clk  in  1: single clock, sourced from the hashing PLL output.
REQ-004 reset  in  1: asynchronous, active-high.
REQ-005 rx_work_valid  in  1: new work offered.
REQ-006 tx_work_ready  out  1: work may be accepted.
REQ-007 rx_midstate  in  256; rx_data  in  96: work payload.
REQ-008 tx_midstate  out  256; tx_data  out  96: registered work presented to the hashing cores.
REQ-009 tx_nonce  out  32: nonce issued this cycle.
REQ-010 tx_hash_en  out  1: tx_nonce is valid this cycle.
REQ-011 rx_hit  in  1: a core reports a golden hash for the nonce issued LATENCY cycles earlier.
REQ-012 tx_golden_valid  out  1; tx_golden_nonce  out  32; rx_golden_ready  in  1: valid/ready result port.
REQ-013 tx_exhausted  out  1: one-cycle pulse when the nonce space is exhausted and draining is complete.
REQ-014 tx_dropped  out  8: saturating count of lost hits.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 Work handshake: a transfer occurs when rx_work_valid and tx_work_ready are both high; tx_work_ready = (state is IDLE or RUN).
REQ-017 On transfer:
- latch the payload into tx_midstate/tx_data;
- set tx_nonce=0 and enter RUN;
- tx_hash_en is high from the next cycle.
REQ-018 In RUN, tx_nonce SHALL increase by NONCE_STEP each cycle, modulo 2^32.
REQ-019 When tx_nonce = 2^32-NONCE_STEP is issued, the next state SHALL be DRAIN and tx_hash_en SHALL drop.
REQ-020 DRAIN SHALL last exactly LATENCY cycles, then go to IDLE with tx_exhausted pulsed in the IDLE-entry cycle.
REQ-021 A transfer in RUN SHALL restart at nonce 0 with the new work.
- A flush counter SHALL discard rx_hit for the next LATENCY cycles.
- Stale hits are not counted as dropped.
REQ-022 An rx_hit in RUN or DRAIN (not flushed) SHALL produce golden = (issue counter − LATENCY·NONCE_STEP) mod 2^32.
- The issue counter keeps advancing internally during DRAIN.
REQ-023 rx_hit in IDLE, or before LATENCY cycles of issue have elapsed since work acceptance, SHALL be ignored.
REQ-024 Results SHALL pass through a 2-entry FIFO.
- tx_golden_valid = FIFO not empty; head on tx_golden_nonce.
- An entry pops when tx_golden_valid and rx_golden_ready are both high.
REQ-025 A hit with the FIFO full and no pop in the same cycle SHALL be dropped and tx_dropped incremented, saturating at 255.
- A simultaneous push and pop on a full FIFO SHALL succeed.
REQ-026 Hit-to-tx_golden_valid latency SHALL be 1 cycle with the FIFO empty.
REQ-027 The FIFO SHALL survive work changes; pending results remain valid.

Reset
REQ-028 On reset:
- state=IDLE; tx_nonce=0;
- tx_midstate, tx_data = 0;
- tx_hash_en, tx_golden_valid, tx_exhausted = 0;
- tx_dropped=0; FIFO empty; flush counter=0.
REQ-029 Reset mid-RUN/DRAIN SHALL discard all in-flight work and results immediately, with no tx_exhausted pulse.

Structure
REQ-030 State encoding, NONCE_W=32 and MIDSTATE_W/DATA_W constants SHALL reside in the shared miner package.
REQ-031 The result FIFO SHALL be a sub-module named golden_fifo (depth 2, width 32).

Verification
REQ-032 Reset, then accept work with NONCE_STEP=1 -> tx_nonce 0,1,2… from the next cycle; tx_hash_en=1.
REQ-033 LATENCY=64; hit 100 cycles after acceptance -> tx_golden_nonce=36, valid one cycle later.
REQ-034 Preload the nonce counter near 0xFFFFFFFF (force) with NONCE_STEP=4 -> last nonce 0xFFFFFFFC; DRAIN 64 cycles; tx_exhausted single pulse; a hit during DRAIN is reported.
REQ-035 rx_golden_ready=0; three hits -> two queued, tx_dropped=1; pop both -> values in order.
REQ-036 New work in RUN followed by a hit 10 cycles later -> hit discarded, tx_nonce restarts at 0, tx_dropped unchanged.
REQ-037 Assert reset during DRAIN -> all outputs reach reset values asynchronously; no tx_exhausted.
